divremsqrt_iter_ctrl: RTL and testbench
=======================================

Name: divremsqrt_iter_ctrl

Overview:
- Sequencing controller for the radix-N iterative divide/remainder/square-root unit.
- Accepts float or integer start requests in the Execute stage.
- Loads the iteration counter and raises busy while the digit-recurrence datapath iterates.
- Ends the operation on count exhaustion, on an exact-result early termination (WZeroE), or immediately for special cases; then holds done until the Memory stage releases it.

Parameters:
- P, cvw_t config, supplies XLEN, DIVb, RADIX, IDIV_ON_FPU.
- DURLEN, 8, width of the iteration counter (must hold max cycle count).
- EARLYTERM, 1, enables termination on WZeroE (0 = always run full count).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- FDivStartE  in  1  float div/sqrt request in E
- IDivStartE  in  1  integer div/rem request in E (ignored when P.IDIV_ON_FPU=0)
- CyclesE  in  DURLEN  iteration count for this op (precomputed, ≥1)
- SpecialCaseE  in  1  NaN/Inf/zero, or int divide-by-zero: no iteration needed
- WZeroE  in  1  exact-remainder early-termination flag from datapath
- StallM  in  1  Memory-stage stall
- FlushE  in  1  Execute-stage flush
- IFDivStartE  out  1  one-cycle pulse: datapath initialise/load
- FDivBusyE  out  1  unit occupied; holds the pipeline
- FDivDoneE  out  1  result ready for E/M register
- IterEnE  out  1  datapath iteration enable (WS/WC/U/UM registers)
- IterCntE  out  DURLEN  remaining iterations (debug/visibility)

Behaviour:
- States are IDLE, BUSY, DONE; the encoding goes in the package.
- Reset (reset==0 at a clk edge) forces:
  - state = IDLE, IterCntE = 0;
  - all 1-bit outputs 0;
  - this applies in any state, including mid-BUSY; the in-flight op is discarded with no done pulse.
- Start = FDivStartE | (IDivStartE & P.IDIV_ON_FPU).
- IFDivStartE = Start & (state==IDLE) & ~FlushE. It is combinational and asserts in the acceptance cycle only.
- IDLE:
  - on IFDivStartE and SpecialCaseE → DONE; IterCntE unchanged (0).
  - on IFDivStartE and ~SpecialCaseE → BUSY; IterCntE <= CyclesE.
  - otherwise remain.
- BUSY:
  - IterEnE = 1. FDivBusyE = 1. Each cycle, IterCntE <= IterCntE-1.
  - Exit to DONE when IterCntE==1, or when (EARLYTERM & WZeroE).
  - When both hold in the same cycle, go to DONE once (no double event).
  - On the exit transition IterCntE <= 0.
  - Latency start→done = min(CyclesE, first WZeroE cycle+1) + 1 cycles.
- DONE:
  - FDivDoneE = 1, IterEnE = 0.
  - FDivBusyE = StallM (keep holding while M stalls).
  - On ~StallM → IDLE. While StallM, remain in DONE.
- FDivBusyE is also 1 in IDLE in the acceptance cycle when not SpecialCaseE, so the pipeline stalls from the first cycle.
- FlushE:
  - from BUSY or DONE → IDLE next edge; IterCntE <= 0.
  - in IDLE it suppresses acceptance.
  - flush has priority over all transitions except reset.
- Start while BUSY/DONE is ignored (no queueing). The requester holds it until accepted.
- Counter never wraps: decrement only in BUSY with IterCntE ≥ 1.
- CyclesE==1 is legal and gives exactly one BUSY cycle. CyclesE==0 is illegal; treat as 1 (assertion fires in simulation).
- The integer and float paths are sequenced identically; only the source of CyclesE differs (outside this block).

Decomposition:
- Shared package (cvw-side divsqrt package) holds:
  - the state enum typedef (IDLE/BUSY/DONE);
  - DURLEN derivation from P (clog2 of the max of the float and integer cycle counts).
- One sub-module, divremsqrt_itercounter: a loadable down-counter with load, en, clear, and a "one" flag.
- The FSM and output decode stay in the top.

Test Plan:
- Reset mid-op: start CyclesE=10, drop reset at iteration 4 → all outputs 0 next edge, no FDivDoneE ever, state IDLE.
- Full run: FDivStartE, CyclesE=5, WZeroE=0, StallM=0 → IFDivStartE one cycle, IterEnE 5 cycles, FDivDoneE at cycle 6, IDLE at cycle 7.
- Early termination: CyclesE=20, WZeroE asserted in BUSY cycle 3 → DONE next cycle, IterCntE=0, total busy 4 cycles.
- Special case: FDivStartE with SpecialCaseE=1 → no IterEnE, FDivDoneE the following cycle.
- Stall in DONE: StallM high 3 cycles on reaching DONE → FDivDoneE and FDivBusyE held 3 cycles, IDLE one cycle after StallM falls.
- Flush and back-to-back:
  - FlushE in BUSY cycle 2 → IDLE next edge.
  - Start during BUSY is ignored.
  - IDivStartE with IDIV_ON_FPU=0 is never accepted.

Source files
------------

// File: rtl/divremsqrt_iter_ctrl_pkg.sv
// Shared types and sizing helpers for the iterative div/rem/sqrt sequencer.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package divremsqrt_iter_ctrl_pkg;

    // Subset of the core configuration that the divider sequencing depends on.
    typedef struct packed {
        int unsigned XLEN;
        int unsigned DIVb;
        int unsigned RADIX;
        logic        IDIV_ON_FPU;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 64, DIVb: 64, RADIX: 4, IDIV_ON_FPU: 1'b1};

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divstate_t;

    // Quotient bits retired per iteration; radix 2 or below still yields one bit.
    function automatic int unsigned bits_per_cycle(cvw_t cfg);
        int unsigned lg;
        lg = $clog2(cfg.RADIX);
        return (lg == 0) ? 1 : lg;
    endfunction

    // Float div/sqrt iterations: ceil(DIVb / bits) plus one normalisation cycle.
    function automatic int unsigned fdiv_cycles(cvw_t cfg);
        int unsigned b;
        b = bits_per_cycle(cfg);
        return (cfg.DIVb + b - 1) / b + 1;
    endfunction

    // Integer div/rem iterations; zero when integer ops do not use this unit.
    function automatic int unsigned idiv_cycles(cvw_t cfg);
        int unsigned b;
        b = bits_per_cycle(cfg);
        return cfg.IDIV_ON_FPU ? ((cfg.XLEN + b - 1) / b + 1) : 0;
    endfunction

    // Counter width able to hold the longest iteration count of either path.
    function automatic int unsigned durlen_of(cvw_t cfg);
        int unsigned f;
        int unsigned i;
        int unsigned m;
        f = fdiv_cycles(cfg);
        i = idiv_cycles(cfg);
        m = (f > i) ? f : i;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/divremsqrt_itercounter.sv
// Loadable saturating down-counter holding the remaining iteration count.
// Latency: load/clear/decrement take effect at the next clk edge; one is combinational.
// Backpressure: none; en simply holds the value when low.
module divremsqrt_itercounter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] loadval,
    output logic [W-1:0] cnt,
    output logic         one
);

    // Clear beats load beats decrement; a zero load is promoted to one so the
    // datapath always gets at least one iteration, and the count never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (loadval == '0) ? W'(1) : loadval;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign one = (cnt == W'(1));

endmodule

// File: rtl/divremsqrt_iter_ctrl.sv
// Sequencer for the iterative div/rem/sqrt datapath: accept, iterate, hold result.
// Latency: start->done = min(CyclesE, first WZeroE cycle + 1) + 1; special cases 1.
// Backpressure: FDivBusyE stalls the pipe from acceptance; done is held while StallM.
module divremsqrt_iter_ctrl
    import divremsqrt_iter_ctrl_pkg::*;
#(
    parameter cvw_t P         = CVW_DEFAULT,
    parameter int   DURLEN    = 8,
    parameter bit   EARLYTERM = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FDivStartE,
    input  logic              IDivStartE,
    input  logic [DURLEN-1:0] CyclesE,
    input  logic              SpecialCaseE,
    input  logic              WZeroE,
    input  logic              StallM,
    input  logic              FlushE,
    output logic              IFDivStartE,
    output logic              FDivBusyE,
    output logic              FDivDoneE,
    output logic              IterEnE,
    output logic [DURLEN-1:0] IterCntE
);

    divstate_t state;
    divstate_t state_n;

    logic start;
    logic accept;
    logic cnt_load;
    logic cnt_en;
    logic cnt_clear;
    logic cnt_one;

    // Integer requests only count when integer division shares this unit.
    assign start  = FDivStartE | (IDivStartE & P.IDIV_ON_FPU);
    // Acceptance is suppressed by flush and by a reset in the same cycle.
    assign accept = start & (state == IDLE) & ~FlushE & reset;

    divremsqrt_itercounter #(.W(DURLEN)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .load    (cnt_load),
        .en      (cnt_en),
        .loadval (CyclesE),
        .cnt     (IterCntE),
        .one     (cnt_one)
    );

    // State register; reset discards any in-flight operation without a done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and output decode; flush wins over every other transition.
    always_comb begin
        state_n     = state;
        IFDivStartE = accept;
        FDivBusyE   = 1'b0;
        FDivDoneE   = 1'b0;
        IterEnE     = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (SpecialCaseE) begin
                        state_n = DONE;
                    end else begin
                        // Stall the pipe from the acceptance cycle itself.
                        FDivBusyE = 1'b1;
                        cnt_load  = 1'b1;
                        state_n   = BUSY;
                    end
                end
            end
            BUSY: begin
                IterEnE   = 1'b1;
                FDivBusyE = 1'b1;
                if (FlushE) begin
                    cnt_clear = 1'b1;
                    state_n   = IDLE;
                end else if (cnt_one || (EARLYTERM && WZeroE)) begin
                    // Count exhaustion and early termination share one exit.
                    cnt_clear = 1'b1;
                    state_n   = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                FDivDoneE = 1'b1;
                FDivBusyE = StallM;
                if (FlushE) begin
                    cnt_clear = 1'b1;
                    state_n   = IDLE;
                end else if (!StallM) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A zero iteration count is a caller error; the counter runs it as one.
    ap_cycles_nonzero: assert property (@(posedge clk) disable iff (!reset)
        cnt_load |-> (CyclesE != '0));

endmodule

// File: tb/tb_divremsqrt_iter_ctrl.sv
// Directed bench for divremsqrt_iter_ctrl with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_divremsqrt_iter_ctrl;
    import divremsqrt_iter_ctrl_pkg::*;

    localparam cvw_t CFG = '{XLEN: 64, DIVb: 64, RADIX: 4, IDIV_ON_FPU: 1'b0};
    localparam int   DL  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          FDivStartE, IDivStartE, SpecialCaseE, WZeroE, StallM, FlushE;
    logic [DL-1:0] CyclesE;
    logic          IFDivStartE, FDivBusyE, FDivDoneE, IterEnE;
    logic [DL-1:0] IterCntE;

    int checks = 0;
    int errors = 0;

    divremsqrt_iter_ctrl #(.P(CFG), .DURLEN(DL), .EARLYTERM(1'b1)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .FDivStartE   (FDivStartE),
        .IDivStartE   (IDivStartE),
        .CyclesE      (CyclesE),
        .SpecialCaseE (SpecialCaseE),
        .WZeroE       (WZeroE),
        .StallM       (StallM),
        .FlushE       (FlushE),
        .IFDivStartE  (IFDivStartE),
        .FDivBusyE    (FDivBusyE),
        .FDivDoneE    (FDivDoneE),
        .IterEnE      (IterEnE),
        .IterCntE     (IterCntE)
    );

    always #5 clk = ~clk;

    // Reference model: iterations still owed, and whether a result is being held.
    int   m_left = 0;
    bit   m_fin  = 1'b0;
    int   cyc    = 0;
    bit   chk_en = 1'b0;
    logic m_accept;

    assign m_accept = rst_n && (m_left == 0) && !m_fin && !FlushE &&
                      (FDivStartE || (IDivStartE && CFG.IDIV_ON_FPU));

    always @(posedge clk) begin
        bit acc;
        acc = m_accept;
        cyc++;
        if (!rst_n) begin
            m_left = 0;
            m_fin  = 1'b0;
        end else if (m_left > 0) begin
            if (FlushE) begin
                m_left = 0;
            end else if (m_left == 1 || WZeroE) begin
                m_left = 0;
                m_fin  = 1'b1;
            end else begin
                m_left = m_left - 1;
            end
        end else if (m_fin) begin
            if (FlushE || !StallM) m_fin = 1'b0;
        end else if (acc) begin
            if (SpecialCaseE) m_fin = 1'b1;
            else m_left = (CyclesE == 0) ? 1 : int'(CyclesE);
        end
    end

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-test observations of the DUT, used for the hand-computed expectations.
    int start_pulses, iter_cycles, busy_cycles, done_cycles, start_cyc, first_done;

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("cmp_IFDivStartE", IFDivStartE, m_accept);
            check_bit("cmp_IterEnE", IterEnE, m_left > 0);
            check_bit("cmp_FDivDoneE", FDivDoneE, m_fin);
            check_bit("cmp_FDivBusyE", FDivBusyE,
                      (m_left > 0) || (m_fin && StallM) || (m_accept && !SpecialCaseE));
            check_val("cmp_IterCntE", int'(IterCntE), m_left);
            if (IFDivStartE === 1'b1) begin
                start_pulses++;
                if (start_cyc < 0) start_cyc = cyc;
            end
            if (IterEnE === 1'b1) iter_cycles++;
            if (FDivBusyE === 1'b1) busy_cycles++;
            if (FDivDoneE === 1'b1) begin
                done_cycles++;
                if (first_done < 0) first_done = cyc;
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_stats();
        start_pulses = 0;
        iter_cycles  = 0;
        busy_cycles  = 0;
        done_cycles  = 0;
        start_cyc    = -1;
        first_done   = -1;
    endtask

    task automatic wait_idle(string name, int maxc);
        int k;
        k = 0;
        while ((IterEnE || FDivDoneE || FDivBusyE) && k < maxc) begin
            step(1);
            k++;
        end
        check_bit({name, "_reached_idle"}, !(IterEnE || FDivDoneE || FDivBusyE), 1'b1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; FDivStartE = 1'b0; IDivStartE = 1'b0; SpecialCaseE = 1'b0;
        WZeroE = 1'b0; StallM = 1'b0; FlushE = 1'b0; CyclesE = '0;
        clr_stats();
        step(2);
        chk_en = 1'b1;
        check_bit("rst_IFDivStartE", IFDivStartE, 1'b0);
        check_bit("rst_FDivBusyE", FDivBusyE, 1'b0);
        check_bit("rst_FDivDoneE", FDivDoneE, 1'b0);
        check_bit("rst_IterEnE", IterEnE, 1'b0);
        check_val("rst_IterCntE", int'(IterCntE), 0);
        rst_n = 1'b1;
        step(1);

        // Full run, 5 iterations.
        clr_stats();
        CyclesE = 8'd5; FDivStartE = 1'b1;
        step(1);
        FDivStartE = 1'b0;
        wait_idle("full", 20);
        check_val("full_starts", start_pulses, 1);
        check_val("full_iters", iter_cycles, 5);
        check_val("full_busy", busy_cycles, 6);
        check_val("full_done", done_cycles, 1);
        check_val("full_latency", first_done - start_cyc, 6);

        // Early termination in the third iteration of 20.
        clr_stats();
        CyclesE = 8'd20; FDivStartE = 1'b1;
        step(1);
        FDivStartE = 1'b0;
        step(2);
        check_val("early_cnt_c3", int'(IterCntE), 18);
        WZeroE = 1'b1;
        step(1);
        WZeroE = 1'b0;
        check_bit("early_done", FDivDoneE, 1'b1);
        check_val("early_cnt_done", int'(IterCntE), 0);
        wait_idle("early", 10);
        check_val("early_iters", iter_cycles, 3);
        check_val("early_busy", busy_cycles, 4);
        check_val("early_latency", first_done - start_cyc, 4);

        // Special case completes without iterating.
        clr_stats();
        CyclesE = 8'd7; SpecialCaseE = 1'b1; FDivStartE = 1'b1;
        step(1);
        FDivStartE = 1'b0; SpecialCaseE = 1'b0;
        check_bit("special_done", FDivDoneE, 1'b1);
        wait_idle("special", 10);
        check_val("special_iters", iter_cycles, 0);
        check_val("special_busy", busy_cycles, 0);
        check_val("special_latency", first_done - start_cyc, 1);

        // Memory stall while holding the result.
        clr_stats();
        CyclesE = 8'd2; FDivStartE = 1'b1;
        step(1);
        FDivStartE = 1'b0;
        step(2);
        StallM = 1'b1;
        step(3);
        StallM = 1'b0;
        check_bit("stall_done_held", FDivDoneE, 1'b1);
        step(1);
        check_bit("stall_released", FDivDoneE, 1'b0);
        wait_idle("stall", 10);
        check_val("stall_done_cycles", done_cycles, 4);
        check_val("stall_busy", busy_cycles, 6);

        // Flush in the second iteration, then flush blocking acceptance.
        clr_stats();
        CyclesE = 8'd10; FDivStartE = 1'b1;
        step(1);
        FDivStartE = 1'b0;
        step(1);
        FlushE = 1'b1;
        step(1);
        FlushE = 1'b0;
        check_bit("flush_iter_off", IterEnE, 1'b0);
        check_val("flush_cnt", int'(IterCntE), 0);
        wait_idle("flush", 10);
        check_val("flush_iters", iter_cycles, 2);
        check_val("flush_done", done_cycles, 0);
        clr_stats();
        FDivStartE = 1'b1; FlushE = 1'b1;
        step(2);
        FDivStartE = 1'b0; FlushE = 1'b0;
        check_val("flushidle_starts", start_pulses, 0);

        // Held start: ignored while occupied, re-accepted back-to-back.
        clr_stats();
        CyclesE = 8'd3; FDivStartE = 1'b1;
        step(1);
        CyclesE = 8'd2;
        k = 0;
        while (start_pulses < 2 && k < 20) begin
            step(1);
            k++;
        end
        FDivStartE = 1'b0;
        wait_idle("b2b", 10);
        check_val("b2b_starts", start_pulses, 2);
        check_val("b2b_iters", iter_cycles, 5);
        check_val("b2b_done", done_cycles, 2);

        // Integer requests are not served by this configuration.
        clr_stats();
        CyclesE = 8'd4; IDivStartE = 1'b1;
        step(4);
        IDivStartE = 1'b0;
        check_val("idiv_starts", start_pulses, 0);
        check_val("idiv_busy", busy_cycles, 0);

        // Single-iteration operation.
        clr_stats();
        CyclesE = 8'd1; FDivStartE = 1'b1;
        step(1);
        FDivStartE = 1'b0;
        wait_idle("one", 10);
        check_val("one_iters", iter_cycles, 1);
        check_val("one_latency", first_done - start_cyc, 2);

        // Reset in the fourth iteration discards the operation.
        clr_stats();
        CyclesE = 8'd10; FDivStartE = 1'b1;
        step(1);
        FDivStartE = 1'b0;
        step(3);
        rst_n = 1'b0;
        step(1);
        check_bit("rstmid_busy", FDivBusyE, 1'b0);
        check_bit("rstmid_iter", IterEnE, 1'b0);
        check_bit("rstmid_done", FDivDoneE, 1'b0);
        check_val("rstmid_cnt", int'(IterCntE), 0);
        rst_n = 1'b1;
        step(15);
        check_val("rstmid_no_done", done_cycles, 0);
        check_val("rstmid_iters", iter_cycles, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
